// File: rtl/pipelined_cla_adder.sv
// Elastic carry-lookahead adder/subtractor, one 16-bit CLA slice per pipeline stage.
// Latency: WIDTH/16 cycles from input acceptance to out_valid, one beat per cycle.
// Backpressure: per-stage ready chain; bubbles collapse, in_ready drops only when every stage holds a beat.
module pipelined_cla_adder #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Gout,
    output logic             Pout,
    output logic             Ovf
);
    localparam int NSTAGE = WIDTH / 16;

    if ((WIDTH % 16) != 0 || WIDTH < 16) begin : g_bad_width
        $error("pipelined_cla_adder: WIDTH must be a positive multiple of 16");
    end

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        g;
        logic        p;
        logic        cmsb;
    } cla_t;

    // a/b keep the full word; each stage only reads its own slice
    typedef struct packed {
        logic             vld;
        logic             c;
        logic             g;
        logic             p;
        logic             cm;
        logic [WIDTH-1:0] s;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } stage_t;

    function automatic cla_t cla16(input logic [15:0] a, input logic [15:0] b, input logic cin);
        logic [15:0] g, p, c;
        logic [3:0]  gg, pg;
        logic [4:0]  cg;
        cla_t        r;
        g = a & b;
        p = a ^ b;
        for (int j = 0; j < 4; j++) begin
            gg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                  | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
            pg[j] = &p[4*j +: 4];
        end
        cg[0] = cin;
        cg[1] = gg[0] | (pg[0] & cin);
        cg[2] = gg[1] | (pg[1] & gg[0]) | (pg[1] & pg[0] & cin);
        cg[3] = gg[2] | (pg[2] & gg[1]) | (pg[2] & pg[1] & gg[0]) | (pg[2] & pg[1] & pg[0] & cin);
        cg[4] = gg[3] | (pg[3] & gg[2]) | (pg[3] & pg[2] & gg[1]) | (pg[3] & pg[2] & pg[1] & gg[0])
              | (pg[3] & pg[2] & pg[1] & pg[0] & cin);
        for (int j = 0; j < 4; j++) begin
            c[4*j]   = cg[j];
            c[4*j+1] = g[4*j] | (p[4*j] & cg[j]);
            c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & cg[j]);
            c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j])
                     | (p[4*j+2] & p[4*j+1] & p[4*j] & cg[j]);
        end
        r.sum  = p ^ c;
        r.cout = cg[4];
        r.g    = gg[3] | (pg[3] & gg[2]) | (pg[3] & pg[2] & gg[1]) | (pg[3] & pg[2] & pg[1] & gg[0]);
        r.p    = &pg;
        r.cmsb = c[15];
        return r;
    endfunction

    stage_t              st_q [NSTAGE];
    stage_t              tap  [NSTAGE];
    stage_t              nxt  [NSTAGE];
    cla_t                r;
    logic [NSTAGE-1:0]   rdy;
    logic                rdy_acc;

    always_comb begin
        // tap[k] is what stage k would load: the input beat or the previous stage
        tap[0]     = '0;
        tap[0].vld = in_valid;
        tap[0].c   = sub | in;
        tap[0].p   = 1'b1;
        tap[0].a   = A;
        tap[0].b   = sub ? ~B : B;
        for (int k = 1; k < NSTAGE; k++) begin
            tap[k] = st_q[k-1];
        end
        r = '0;
        for (int k = 0; k < NSTAGE; k++) begin
            r                    = cla16(tap[k].a[16*k +: 16], tap[k].b[16*k +: 16], tap[k].c);
            nxt[k]               = tap[k];
            nxt[k].s[16*k +: 16] = r.sum;
            nxt[k].c             = r.cout;
            nxt[k].g             = r.g | (r.p & tap[k].g);
            nxt[k].p             = r.p & tap[k].p;
            nxt[k].cm            = r.cmsb;
        end
    end

    always_comb begin
        rdy_acc = out_ready;
        rdy     = '0;
        for (int k = NSTAGE - 1; k >= 0; k--) begin
            rdy_acc = rdy_acc | ~st_q[k].vld;
            rdy[k]  = rdy_acc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NSTAGE; k++) begin
                st_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NSTAGE; k++) begin
                if (rdy[k]) begin
                    if (tap[k].vld) begin
                        st_q[k] <= nxt[k];
                    end else begin
                        st_q[k].vld <= 1'b0;
                    end
                end
            end
        end
    end

    assign in_ready  = rst_n & rdy[0];
    assign out_valid = st_q[NSTAGE-1].vld;
    assign S         = st_q[NSTAGE-1].s;
    assign Cout      = st_q[NSTAGE-1].c;
    assign Gout      = st_q[NSTAGE-1].g;
    assign Pout      = st_q[NSTAGE-1].p;
    assign Ovf       = st_q[NSTAGE-1].cm ^ st_q[NSTAGE-1].c;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Scoreboard bench for pipelined_cla_adder: 32-bit main instance plus a 16-bit single-stage instance.
module tb_pipelined_cla_adder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready;
    logic [31:0] a = '0, b = '0, s;
    logic        cin = 1'b0, sub = 1'b0;
    logic        out_valid, out_ready = 1'b1;
    logic        cout, gout, pout, ovf;

    logic        iv16 = 1'b0, ir16, ov16, ordy16 = 1'b1;
    logic [15:0] a16 = '0, b16 = '0, s16;
    logic        ci16 = 1'b0, sub16 = 1'b0;
    logic        c16, g16, p16, o16;

    always #5 clk = ~clk;

    pipelined_cla_adder #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(a), .B(b), .in(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .S(s), .Cout(cout), .Gout(gout), .Pout(pout), .Ovf(ovf)
    );

    pipelined_cla_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
        .A(a16), .B(b16), .in(ci16), .sub(sub16),
        .out_valid(ov16), .out_ready(ordy16),
        .S(s16), .Cout(c16), .Gout(g16), .Pout(p16), .Ovf(o16)
    );

    typedef struct {
        logic [31:0] s;
        logic        c, g, p, o;
        int          cyc;
        bit          lat;
    } exp_t;

    exp_t        sb_q[$];
    int          n_chk = 0, n_err = 0, cyc = 0;
    bit          lat_on = 1'b0, held = 1'b0;
    logic [36:0] snap = '0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] ta, input logic [31:0] tbv, input logic ci, input logic sb);
        exp_t        e;
        logic [31:0] bx;
        logic [32:0] full, nc;
        bx    = sb ? ~tbv : tbv;
        full  = {1'b0, ta} + {1'b0, bx} + {32'd0, (sb | ci)};
        nc    = {1'b0, ta} + {1'b0, bx};
        e.s   = full[31:0];
        e.c   = full[32];
        e.g   = nc[32];
        e.p   = &(ta ^ bx);
        e.o   = (full[31] ^ ta[31] ^ bx[31]) ^ full[32];
        e.cyc = 0;
        e.lat = 1'b0;
        return e;
    endfunction

    // One cycle: drive at negedge, sample 1 ns later, pop on output transfer, push on input transfer.
    task automatic step(input logic r, input logic iv, input logic [31:0] ta, input logic [31:0] tbv,
                        input logic ci, input logic sb, input logic ordy, output bit acc);
        exp_t e;
        @(negedge clk);
        cyc++;
        rst_n = r; in_valid = iv; a = ta; b = tbv; cin = ci; sub = sb; out_ready = ordy;
        #1;
        acc = 1'b0;
        if (held) check_eq("stall_hold", 64'({out_valid, cout, gout, pout, ovf, s}), 64'(snap));
        held = rst_n && out_valid && !out_ready;
        snap = {out_valid, cout, gout, pout, ovf, s};
        if (!rst_n) begin
            check_eq("rst_in_ready", 64'(in_ready), 64'(0));
            sb_q.delete();
        end else if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check_eq("spurious_out", 64'(out_valid), 64'(0));
            end else begin
                e = sb_q.pop_front();
                check_eq("S", 64'(s), 64'(e.s));
                check_eq("flags_CGPO", 64'({cout, gout, pout, ovf}), 64'({e.c, e.g, e.p, e.o}));
                if (e.lat) check_eq("latency", 64'(cyc - e.cyc), 64'(2));
            end
        end
        if (rst_n && in_valid && in_ready) begin
            e     = model(a, b, cin, sub);
            e.cyc = cyc;
            e.lat = lat_on;
            sb_q.push_back(e);
            acc = 1'b1;
        end
    endtask

    task automatic check_idle(input string tag);
        check_eq(tag, 64'({out_valid, cout, gout, pout, ovf, s}), 64'(0));
    endtask

    task automatic drain();
        bit acc;
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) step(1, 0, 0, 0, 0, 0, 1, acc);
        check_eq("drain_empty", 64'(sb_q.size()), 64'(0));
    endtask

    task automatic send_one(input logic [31:0] ta, input logic [31:0] tbv, input logic ci, input logic sb);
        bit acc;
        step(1, 1, ta, tbv, ci, sb, 1, acc);
        check_eq("accept", 64'(acc), 64'(1));
        step(1, 0, 0, 0, 0, 0, 1, acc);
        check_eq("early_valid", 64'(out_valid), 64'(0));
        drain();
    endtask

    task automatic w16_case(input logic [15:0] ta, input logic [15:0] tbv, input logic ci, input logic sb,
                            input logic [15:0] es, input logic [3:0] eflags);
        @(negedge clk);
        a16 = ta; b16 = tbv; ci16 = ci; sub16 = sb; iv16 = 1'b1;
        #1;
        check_eq("w16_in_ready", 64'(ir16), 64'(1));
        @(negedge clk);
        iv16 = 1'b0;
        #1;
        check_eq("w16_valid", 64'(ov16), 64'(1));
        check_eq("w16_S", 64'(s16), 64'(es));
        check_eq("w16_flags_CGPO", 64'({c16, g16, p16, o16}), 64'(eflags));
        @(negedge clk);
        #1;
        check_eq("w16_consumed", 64'(ov16), 64'(0));
    endtask

    initial begin
        bit          acc;
        logic [31:0] ra [6], rb [6];
        logic        rc [6], rs [6];
        int          idx;

        for (int i = 0; i < 3; i++) begin
            step(0, 1, $urandom, $urandom, 1, 0, 1, acc);
            check_idle("reset_outputs");
        end
        step(1, 0, 0, 0, 0, 0, 1, acc);
        check_eq("release_in_ready", 64'(in_ready), 64'(1));
        check_eq("release_out_valid", 64'(out_valid), 64'(0));
        step(1, 0, 0, 0, 0, 0, 1, acc);
        check_eq("idle_out_valid", 64'(out_valid), 64'(0));

        lat_on = 1'b1;
        send_one(32'h0000FFFF, 32'h00000001, 1'b0, 1'b0);
        send_one(32'd5, 32'd7, 1'b0, 1'b1);
        send_one(32'h80000000, 32'd1, 1'b0, 1'b1);
        send_one(32'hFFFFFFFF, 32'd0, 1'b1, 1'b0);
        send_one(32'h7FFFFFFF, 32'd1, 1'b0, 1'b0);
        lat_on = 1'b0;

        for (int i = 0; i < 6; i++) begin
            ra[i] = $urandom; rb[i] = $urandom;
            rc[i] = 1'($urandom_range(0, 1)); rs[i] = 1'($urandom_range(0, 1));
        end
        idx = 0;
        for (int i = 0; i < 30 && idx < 6; i++) begin
            step(1, 1, ra[idx], rb[idx], rc[idx], rs[idx], !(i >= 3 && i < 7), acc);
            if (i >= 4 && i < 7) check_eq("full_in_ready", 64'(in_ready), 64'(0));
            if (acc) idx++;
        end
        check_eq("bp_accepted", 64'(idx), 64'(6));
        drain();

        for (int i = 0; i < 60; i++) begin
            step(1, 1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, acc);
        end
        drain();

        step(1, 1, $urandom, $urandom, 0, 0, 1, acc);
        step(1, 1, $urandom, $urandom, 0, 1, 1, acc);
        check_eq("two_in_flight", 64'(sb_q.size()), 64'(2));
        step(0, 1, $urandom, $urandom, 0, 0, 0, acc);
        step(1, 0, 0, 0, 0, 0, 1, acc);
        check_idle("midreset_outputs");
        check_eq("midreset_in_ready", 64'(in_ready), 64'(1));
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0, 0, 0, 1, acc);
            check_eq("midreset_no_ghost", 64'(out_valid), 64'(0));
        end
        lat_on = 1'b1;
        send_one(32'h12345678, 32'h0FEDCBA9, 1'b1, 1'b0);
        lat_on = 1'b0;

        w16_case(16'h99DE, 16'hB81B, 1'b1, 1'b0, 16'h51FA, 4'b1101);
        w16_case(16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 4'b0000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/pipelined_cla_adder.md
# pipelined_cla_adder

Parametrised, elastic, pipelined carry-lookahead adder/subtractor. It generalises the 16-bit CLA with lookahead unit to any WIDTH that is a multiple of 16. One 16-bit CLA slice is evaluated per pipeline stage, and the operands are skewed so that one operation can be accepted per cycle. It sits between operand producers and result consumers behind a valid/ready handshake, and reports carry, group generate/propagate and signed overflow.

## Interface
- WIDTH, 32: operand width. Must be a multiple of 16 and at least 16; other values are illegal.
- NSTAGE, WIDTH/16: derived local parameter, not overridable. Number of pipeline stages.

- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  reset; synchronous, active-low.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- in  input  1  carry-in; ignored when sub=1.
- sub  input  1  0 = add, 1 = subtract (A − B).
- out_valid  output  1  result beat valid.
- out_ready  input  1  consumer accepts the result.
- S  output  WIDTH  sum or difference.
- Cout  output  1  carry out of bit WIDTH−1.
- Gout  output  1  group generate of the full word.
- Pout  output  1  group propagate of the full word.
- Ovf  output  1  two's-complement signed overflow.

## Operation
- Effective operand Bx = sub ? ~B : B. Effective carry-in c0 = sub ? 1 : in.
- S = (A + Bx + c0) mod 2^WIDTH. Cout is bit WIDTH of the full sum.
- Subtract: Cout=1 means no borrow (A ≥ B unsigned).
- Gout and Pout are computed from A and Bx only and do not depend on c0. Pout = AND over all bits of (A[i]^Bx[i]). Gout = carry out of the word with c0 = 0.
- Ovf = carry into bit WIDTH−1 XOR Cout.
- Stage k (0..NSTAGE−1) computes slice bits [16k+15:16k] with a 16-bit CLA: 4-bit groups plus a lookahead unit. Its carry-in is c0 for k=0; otherwise it is the registered carry from stage k−1.
- Each stage register holds: the finished lower slices of S, the unconsumed upper slices of A and Bx, the running carry, running G/P, the carry into the MSB, and one valid bit.
- The last stage register drives S, Cout, Gout, Pout, Ovf and out_valid directly. No combinational path runs from A or B to any output.
- Handshake: stage k advances when ready_k = ~valid_k | ready_{k+1}, with ready_NSTAGE = out_ready.
- in_ready = ready_0 while rst_n=1, and 0 while rst_n=0.
- Input transfer occurs on a rising edge with in_valid & in_ready. Output transfer occurs on a rising edge with out_valid & out_ready.
- Results leave in acceptance order. No beat is lost or duplicated.

## Timing
- Reset (rst_n=0 at a rising edge): all valid bits cleared. S=0, Cout=0, Gout=0, Pout=0, Ovf=0, out_valid=0. in_ready=0 while rst_n=0 and returns to 1 in the first cycle after rst_n rises.
- Reset mid-operation: all in-flight beats are discarded and none is ever presented.
- Latency: a beat accepted at edge E appears with out_valid=1 in the cycle after edge E+NSTAGE−1, i.e. NSTAGE cycles (1 for WIDTH=16, 2 for WIDTH=32).
- Throughput: 1 beat/cycle while out_ready=1.
- Stall: while out_valid=1 and out_ready=0, S, Cout, Gout, Pout and Ovf hold stable. Upstream bubbles are still compressed.
- Full: with every stage valid and out_ready=0, in_ready=0.
- Simultaneous events: with every stage valid, out_ready=1 and in_valid=1, one beat exits and one enters on the same edge.
- Operand inputs are don't-care when in_valid=0 and must not alter any stage.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with in_valid=1 -> all outputs 0, in_ready=0, nothing accepted. After release, in_ready=1 and out_valid stays 0 until a beat is sent.
- Cross-stage carry (WIDTH=32): A=0x0000FFFF, B=0x00000001, in=0, sub=0 -> S=0x00010000, Cout=0, Ovf=0, out_valid exactly 2 cycles after acceptance.
- Subtract (WIDTH=32): A=5, B=7, sub=1 -> S=0xFFFFFFFE, Cout=0, Ovf=0. Then A=0x80000000, B=1, sub=1 -> S=0x7FFFFFFF, Cout=1, Ovf=1.
- Full propagate (WIDTH=32): A=0xFFFFFFFF, B=0, in=1 -> S=0, Cout=1, Pout=1, Gout=0. With WIDTH=16: A=0x99DE, B=0xB81B, in=1 -> S=0x51FA, Cout=1, Gout=1, Pout=0.
- Back-pressure (WIDTH=32): stream 6 random beats back-to-back, drop out_ready for 4 cycles mid-stream -> in_ready falls once 2 beats are held, outputs stay stable while stalled, all 6 results match the reference model in order.
- Reset mid-stream: assert rst_n=0 for 1 cycle with 2 beats in flight -> neither beat appears, outputs return to 0, and the next beat after reset completes with normal latency.
